regfile_port_arbiter: RTL

//  Shares one 1-write/N-read latch register file (register_file_1w_multi_port_read) among NUM_REQ requesters.

---
 rtl/regfile_arb_pkg.sv | 31 +++
 rtl/regfile_port_arbiter_if.sv | 31 +++
 rtl/regfile_port_arbiter_rr_pick.sv | 33 +++
 rtl/regfile_port_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and helpers for the register-file port arbiter.
// Optional build macro: REGFILE_ARB_WRITE_BYPASS_EN. When it is defined, a read
// of the address being written in the same cycle returns the write data.
package regfile_arb_pkg;

  // Widest requester count the shared types are sized for.
  localparam int MAX_NUM_REQ = 16;

  // Index width for n requesters. Always at least 1 bit.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int REQ_IDX_W = req_idx_w(MAX_NUM_REQ);

  // Round-robin pointer. Also used for requester indices.
  typedef logic [REQ_IDX_W-1:0] arb_ptr_t;

  // One entry per read port. It records where the port's data goes on the next cycle.
  typedef struct packed {
    logic                 valid;
    logic                 bypass;
    logic [REQ_IDX_W-1:0] idx;
  } rd_route_t;

  // Adds 1 to p and wraps to 0 after n-1.
  function automatic arb_ptr_t ptr_wrap_inc(input arb_ptr_t p, input int n);
    return (int'(p) >= n - 1) ? '0 : p + arb_ptr_t'(1);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus of the register-file port arbiter.
//
// Handshake: a requester raises req_i[r] together with we_i/addr_i/wdata_i and
// keeps all four stable until the cycle where gnt_o[r]=1 (same-cycle,
// combinational grant). The transfer happens on the clock edge that ends that
// cycle. For a read, rvalid_o[r] is high for exactly one cycle after the grant
// edge. rdata_o[r] is valid only in that cycle. A requester can start its next
// request in the cycle right after its grant.
interface regfile_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            we_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            rvalid_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/regfile_port_arbiter_rr_pick.sv
// Round-robin find-first-set.
// Searches req starting at position ptr and wraps around at N.
// Outputs the first set position as a one-hot vector and as an index.
module regfile_rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  arb_ptr_t     ptr,
  output logic [N-1:0] onehot,
  output arb_ptr_t     idx,
  output logic         found
);

  // Checks positions in order of distance from ptr. Every index into req stays constant.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int d = 0; d < N; d++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && req[j] &&
            ((int'(ptr) + d == j) || (int'(ptr) + d - N == j))) begin
          found     = 1'b1;
          onehot[j] = 1'b1;
          idx       = arb_ptr_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Lets NUM_REQ requesters share one register file that has 1 write port and N_READ read ports.
// Each cycle it grants one write and up to N_READ reads. Both are chosen round-robin.
// Read data returns one cycle after the grant.
// Optional build macro: REGFILE_ARB_WRITE_BYPASS_EN. Without it, a read of the
// address being written in the same cycle is held back (the latch is transparent
// during the write). With it, the read is granted and returns the write data.
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_port_arbiter_if.slave        bus,
  output logic [N_READ-1:0]            rf_read_en_o,
  output logic [N_READ*ADDR_WIDTH-1:0] rf_read_addr_o,
  input  logic [N_READ*DATA_WIDTH-1:0] rf_read_data_i,
  output logic                         rf_write_en_o,
  output logic [ADDR_WIDTH-1:0]        rf_write_addr_o,
  output logic [DATA_WIDTH-1:0]        rf_write_data_o
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  arb_ptr_t            wr_ptr, wr_ptr_nxt;
  arb_ptr_t            rd_ptr, rd_ptr_nxt;
  logic [NUM_REQ-1:0]  req_act, wr_req, rd_req, rd_elig, hazard, gnt;
  logic [NUM_REQ-1:0]  wr_onehot;
  arb_ptr_t            wr_idx;
  logic                wr_found;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data;

  logic [NUM_REQ-1:0]  rd_avail  [N_READ];
  logic [NUM_REQ-1:0]  rd_onehot [N_READ];
  arb_ptr_t            rd_idx    [N_READ];
  logic [N_READ-1:0]   rd_found;
  logic [N_READ-1:0]   rd_bypass;
  logic [DW-1:0]       byp_data;
  rd_route_t           route_q   [N_READ];

  // No requester is seen while reset is high. This holds every grant and rf_* strobe at 0.
  assign req_act = rst ? '0 : bus.req_i;
  assign wr_req  = req_act & bus.we_i;
  assign rd_req  = req_act & ~bus.we_i;

  regfile_rr_pick #(.N(NUM_REQ)) u_wr_pick (
    .req    (wr_req),
    .ptr    (wr_ptr),
    .onehot (wr_onehot),
    .idx    (wr_idx),
    .found  (wr_found)
  );

  // Routes the winning writer's address and data to the write port.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_onehot[i]) begin
        wr_addr = bus.addr_i[i*AW +: AW];
        wr_data = bus.wdata_i[i*DW +: DW];
      end
    end
  end

  assign rf_write_en_o   = wr_found;
  assign rf_write_addr_o = wr_addr;
  assign rf_write_data_o = wr_data;

  // Flags each requester whose address matches the write being granted this cycle.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hazard[i] = wr_found && (bus.addr_i[i*AW +: AW] == wr_addr);
    end
  end

`ifdef REGFILE_ARB_WRITE_BYPASS_EN
  logic [DW-1:0] byp_data_q;

  assign rd_elig  = rd_req;
  assign byp_data = byp_data_q;

  // Marks each read port whose reader hits the write granted this cycle.
  always_comb begin
    rd_bypass = '0;
    for (int k = 0; k < N_READ; k++) begin
      rd_bypass[k] = |(rd_onehot[k] & hazard);
    end
  end

  // Saves this cycle's write data so a hazard read can return it next cycle.
  always_ff @(posedge clk) begin
    if (wr_found) begin
      byp_data_q <= wr_data;
    end
  end
`else
  assign rd_elig   = rd_req & ~hazard;
  assign byp_data  = '0;
  assign rd_bypass = '0;
`endif

  // Port k takes the k-th eligible reader after rd_ptr.
  // Each pick stage removes the readers already taken by earlier ports.
  assign rd_avail[0] = rd_elig;
  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    regfile_rr_pick #(.N(NUM_REQ)) u_rd_pick (
      .req    (rd_avail[k]),
      .ptr    (rd_ptr),
      .onehot (rd_onehot[k]),
      .idx    (rd_idx[k]),
      .found  (rd_found[k])
    );
    if (k < N_READ - 1) begin : g_chain
      assign rd_avail[k+1] = rd_avail[k] & ~rd_onehot[k];
    end
  end

  // Drives the read ports. Ports that are not granted show address 0.
  always_comb begin
    rf_read_en_o   = rd_found;
    rf_read_addr_o = '0;
    for (int k = 0; k < N_READ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rd_onehot[k][i]) begin
          rf_read_addr_o[k*AW +: AW] = bus.addr_i[i*AW +: AW];
        end
      end
    end
  end

  // Grant vector: the write winner ORed with every read-port winner.
  always_comb begin
    gnt = wr_onehot;
    for (int k = 0; k < N_READ; k++) begin
      gnt = gnt | rd_onehot[k];
    end
  end
  assign bus.gnt_o = gnt;

  // Next pointers: start after the last winner, or stay put when nobody won.
  always_comb begin
    wr_ptr_nxt = wr_found ? ptr_wrap_inc(wr_idx, NUM_REQ) : wr_ptr;
    rd_ptr_nxt = rd_ptr;
    for (int k = 0; k < N_READ; k++) begin
      if (rd_found[k]) begin
        rd_ptr_nxt = ptr_wrap_inc(rd_idx[k], NUM_REQ);
      end
    end
  end

  // Updates the pointers and records which requester each read port serves.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < N_READ; k++) begin
        route_q[k] <= '0;
      end
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      for (int k = 0; k < N_READ; k++) begin
        route_q[k] <= '{valid: rd_found[k], bypass: rd_bypass[k], idx: rd_idx[k]};
      end
    end
  end

  // Sends each port's data to its requester.
  // A response that falls in a reset cycle is dropped.
  always_comb begin
    bus.rvalid_o = '0;
    bus.rdata_o  = '0;
    for (int k = 0; k < N_READ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rst && route_q[k].valid && (route_q[k].idx == arb_ptr_t'(i))) begin
          bus.rvalid_o[i]          = 1'b1;
          bus.rdata_o[i*DW +: DW]  = route_q[k].bypass ? byp_data
                                                       : rf_read_data_i[k*DW +: DW];
        end
      end
    end
  end

endmodule
